// File: rtl/mio_bus_pkg.sv
// mio_bus_pkg: shared types and constants for the memory-mapped I/O bus
// controller (mio_bus_ws) and its address decoder (mio_addr_dec).
//   state_e          : bus FSM states
//   SLOT_TAG_DEFAULT : address tag per slot, slot i at [4i+3:4i]
//   SLOT_*           : slot index of each standard peripheral
//   ERR_CNT_W        : width of the saturating fault counter
//   WAIT_CNT_W       : width of the per-access wait counter
package mio_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [15:0] SLOT_TAG_DEFAULT = {4'hf, 4'he, 4'hd, 4'h0};

    localparam int SLOT_RAM   = 0;
    localparam int SLOT_PS2   = 1;
    localparam int SLOT_GPIOE = 2;
    localparam int SLOT_GPIOF = 3;

    localparam int ERR_CNT_W  = 8;
    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/mio_addr_dec.sv
// mio_addr_dec: combinational priority decoder from the top address nibble to
// a one-hot slot select. When several slots carry the same tag, the lowest
// index wins.
//   tag  : addr_bus[31:28]
//   sel  : one-hot slot select (all zero on a miss)
//   hit  : at least one slot matched
module mio_addr_dec
    import mio_bus_pkg::*;
#(
    parameter int                    NSLOT    = 4,
    parameter logic [NSLOT*4-1:0]    SLOT_TAG = SLOT_TAG_DEFAULT
) (
    input  logic [3:0]       tag,
    output logic [NSLOT-1:0] sel,
    output logic             hit
);

    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        // Walk from the highest index down so the lowest matching slot is the
        // last writer and therefore has priority.
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (tag == SLOT_TAG[4*i +: 4]) begin
                sel    = '0;
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mio_bus_ws.sv
// mio_bus_ws: memory-mapped I/O bus controller with registered decode,
// request/acknowledge wait states, per-access timeout and error reporting.
//   clk, rst                : clock, asynchronous active-low reset
//   req, mem_w, addr_bus,
//   cpu_data2bus            : CPU request (sampled only in IDLE)
//   cpu_data4bus            : registered read data back to the CPU
//   ready, err              : one-cycle completion pulse and its error flag
//   slot_sel, slot_we,
//   slot_addr, slot_wdata   : latched access presented to the peripherals
//   slot_rdata, slot_ack    : per-slot read data and completion
//   err_addr, err_cnt       : fault log (zero unless MIO_BUS_ERRLOG_EN is defined)
// Build option: define MIO_BUS_ERRLOG_EN to synthesise the fault log registers.
module mio_bus_ws
    import mio_bus_pkg::*;
#(
    parameter int                 NSLOT    = 4,
    parameter int                 DW       = 32,
    parameter logic [NSLOT*4-1:0] SLOT_TAG = SLOT_TAG_DEFAULT,
    parameter int                 RAM_AW   = 11,
    parameter int                 TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  mem_w,
    input  logic [31:0]           addr_bus,
    input  logic [DW-1:0]         cpu_data2bus,
    output logic [DW-1:0]         cpu_data4bus,
    output logic                  ready,
    output logic                  err,
    output logic [NSLOT-1:0]      slot_sel,
    output logic                  slot_we,
    output logic [RAM_AW-1:0]     slot_addr,
    output logic [DW-1:0]         slot_wdata,
    input  logic [NSLOT*DW-1:0]   slot_rdata,
    input  logic [NSLOT-1:0]      slot_ack,
    output logic [31:0]           err_addr,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    state_e                state_d, state_q;
    logic [NSLOT-1:0]      slot_sel_d, slot_sel_q;
    logic                  mem_w_d, mem_w_q;
    logic [RAM_AW-1:0]     slot_addr_d, slot_addr_q;
    logic [DW-1:0]         wdata_d, wdata_q;
    logic [DW-1:0]         rdata_d, rdata_q;
    logic [WAIT_CNT_W-1:0] cnt_d, cnt_q;
    logic                  ready_d, ready_q;
    logic                  err_d, err_q;

    logic [NSLOT-1:0]      dec_sel;
    logic                  dec_hit;
    logic [DW-1:0]         sel_rdata;
    logic                  sel_ack;
    logic [WAIT_CNT_W-1:0] cnt_inc;

    mio_addr_dec #(
        .NSLOT    (NSLOT),
        .SLOT_TAG (SLOT_TAG)
    ) u_dec (
        .tag (addr_bus[31:28]),
        .sel (dec_sel),
        .hit (dec_hit)
    );

    // slot_sel_q is one-hot, so an AND-OR mux picks the selected slot's data.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot_sel_q[i]) sel_rdata = sel_rdata | slot_rdata[DW*i +: DW];
        end
    end

    assign sel_ack = |(slot_ack & slot_sel_q);
    assign cnt_inc = cnt_q + WAIT_CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        slot_sel_d  = slot_sel_q;
        mem_w_d     = mem_w_q;
        slot_addr_d = slot_addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    mem_w_d     = mem_w;
                    slot_addr_d = addr_bus[RAM_AW+1:2];
                    wdata_d     = cpu_data2bus;
                    cnt_d       = '0;
                    if (dec_hit) begin
                        slot_sel_d = dec_sel;
                        state_d    = ACCESS;
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc;
                // Ack is tested first so an ack landing on the timeout cycle wins.
                if (sel_ack) begin
                    if (!mem_w_q) rdata_d = sel_rdata;
                    slot_sel_d = '0;
                    cnt_d      = '0;
                    ready_d    = 1'b1;
                    state_d    = RESP;
                end else if (cnt_inc == WAIT_CNT_W'(TIMEOUT)) begin
                    slot_sel_d = '0;
                    cnt_d      = '0;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                slot_sel_d = '0;
                cnt_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    // NOTE: the datapath registers are reset too: slot_addr/slot_wdata are
    // visible ports and must read zero out of reset, and the reset is what
    // drops slot_sel asynchronously when an access is aborted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            slot_sel_q  <= '0;
            mem_w_q     <= 1'b0;
            slot_addr_q <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_sel_q  <= slot_sel_d;
            mem_w_q     <= mem_w_d;
            slot_addr_q <= slot_addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    assign cpu_data4bus = rdata_q;
    assign ready        = ready_q;
    assign err          = err_q;
    assign slot_sel     = slot_sel_q;
    assign slot_we      = mem_w_q & (|slot_sel_q);
    assign slot_addr    = slot_addr_q;
    assign slot_wdata   = wdata_q;

`ifdef MIO_BUS_ERRLOG_EN
    logic [31:0]          faddr_d, faddr_q;
    logic [31:0]          err_addr_d, err_addr_q;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    always_comb begin
        faddr_d    = faddr_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (state_q == IDLE && req) faddr_d = addr_bus;
        if (ready_d && err_d) begin
            // A miss completes straight from IDLE, before faddr_q is loaded.
            err_addr_d = (state_q == IDLE) ? addr_bus : faddr_q;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            faddr_q    <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            faddr_q    <= faddr_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;
`else
    assign err_addr = '0;
    assign err_cnt  = '0;
`endif

    // Only the tag and word-address bits steer the bus without the fault log.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_bus;

endmodule

// File: tb/tb_mio_bus_ws.sv
module tb_mio_bus_ws;

    localparam int NSLOT = 4;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                req = 1'b0;
    logic                mem_w = 1'b0;
    logic [31:0]         addr_bus = '0;
    logic [DW-1:0]       cpu_data2bus = '0;
    logic [DW-1:0]       cpu_data4bus;
    logic                ready;
    logic                err;
    logic [NSLOT-1:0]    slot_sel;
    logic                slot_we;
    logic [10:0]         slot_addr;
    logic [DW-1:0]       slot_wdata;
    logic [NSLOT*DW-1:0] slot_rdata;
    logic [NSLOT-1:0]    slot_ack;
    logic [31:0]         err_addr;
    logic [7:0]          err_cnt;

    mio_bus_ws #(
        .NSLOT    (NSLOT),
        .DW       (DW),
        .SLOT_TAG ({4'hf, 4'he, 4'hd, 4'h0}),
        .RAM_AW   (11),
        .TIMEOUT  (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .mem_w        (mem_w),
        .addr_bus     (addr_bus),
        .cpu_data2bus (cpu_data2bus),
        .cpu_data4bus (cpu_data4bus),
        .ready        (ready),
        .err          (err),
        .slot_sel     (slot_sel),
        .slot_we      (slot_we),
        .slot_addr    (slot_addr),
        .slot_wdata   (slot_wdata),
        .slot_rdata   (slot_rdata),
        .slot_ack     (slot_ack),
        .err_addr     (err_addr),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Peripheral model: each slot acks after ack_delay[i] cycles of selection
    // (0 = combinational ack, 255 = never). noise_ack drives unselected acks.
    logic [31:0] rd [NSLOT];
    int          ack_delay [NSLOT];
    logic        noise_ack = 1'b0;
    int          acc_cyc = 0;
    int          cyc = 0;

    initial begin
        for (int i = 0; i < NSLOT; i++) begin
            rd[i]        = '0;
            ack_delay[i] = 0;
        end
    end

    assign slot_rdata = {rd[3], rd[2], rd[1], rd[0]};

    always_comb begin
        slot_ack = '0;
        for (int i = 0; i < NSLOT; i++)
            slot_ack[i] = slot_sel[i] ? (acc_cyc >= ack_delay[i]) : noise_ack;
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        acc_cyc <= (|slot_sel) ? acc_cyc + 1 : 0;
    end

    // Scoreboard
    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("resp_err",   32'(err), 32'(e.err));
                check("resp_data",  cpu_data4bus, e.data);
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one access from a negedge in IDLE; ends on a negedge in IDLE.
    task automatic access(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] esel,
                          input logic eerr, input logic [31:0] edata, input int lat);
        int sel_cnt = 0;
        bit got = 1'b0;
        sb.push_back('{eerr, edata, cyc + lat});
        addr_bus     = a;
        mem_w        = w;
        cpu_data2bus = d;
        req          = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check({tag, "_sel"}, 32'(slot_sel), 32'(esel));
                if (esel != 0) begin
                    check({tag, "_addr"},  32'(slot_addr), 32'(a[12:2]));
                    check({tag, "_we"},    32'(slot_we), 32'(w));
                    check({tag, "_wdata"}, slot_wdata, d);
                end else begin
                    check({tag, "_we"}, 32'(slot_we), 32'd0);
                end
            end
            if (slot_sel != 0) sel_cnt++;
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        req = 1'b0;
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_sel_cycles"}, 32'(sel_cnt), (esel != 0) ? 32'(lat - 1) : 32'd0);
        @(negedge clk);
    endtask

    task automatic check_log(input string tag, input logic [31:0] ea, input logic [7:0] ec);
`ifdef MIO_BUS_ERRLOG_EN
        check({tag, "_err_addr"}, err_addr, ea);
        check({tag, "_err_cnt"},  32'(err_cnt), 32'(ec));
`else
        check({tag, "_err_addr"}, err_addr, 32'(ea & 32'h0));
        check({tag, "_err_cnt"},  32'(err_cnt), 32'(ec & 8'h0));
`endif
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rdata", cpu_data4bus, 32'h0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_sel",   32'(slot_sel), 32'd0);
        check("rst_we",    32'(slot_we), 32'd0);
        check("rst_addr",  32'(slot_addr), 32'd0);
        check("rst_wdata", slot_wdata, 32'h0);
        check_log("rst", 32'h0, 8'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Read slot 0, combinational ack
        rd[0] = 32'h1234_5678;
        ack_delay[0] = 0;
        access("rd_s0", 32'h0000_0010, 1'b0, 32'h0, 4'b0001, 1'b0, 32'h1234_5678, 2);

        // Write slot 2, ack after 3 cycles
        ack_delay[2] = 3;
        rd[2] = 32'hFFFF_0000;
        access("wr_s2", 32'he000_0000, 1'b1, 32'hA5A5_0001, 4'b0100, 1'b0, 32'h1234_5678, 5);

        // Unmapped address
        access("miss", 32'h5000_0000, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h1234_5678, 1);
        check_log("miss", 32'h5000_0000, 8'd1);

        // Slot 3 never acks; unselected acks held high must be ignored
        rd[3] = 32'hDEAD_BEEF;
        ack_delay[3] = 255;
        noise_ack = 1'b1;
        access("tmo_s3", 32'hf000_0040, 1'b0, 32'h0, 4'b1000, 1'b1, 32'h1234_5678, 16);
        noise_ack = 1'b0;
        check_log("tmo", 32'hf000_0040, 8'd2);

        // Ack arrives on the same cycle the counter reaches TIMEOUT
        ack_delay[3] = 14;
        access("edge_s3", 32'hf000_0044, 1'b0, 32'h0, 4'b1000, 1'b0, 32'hDEAD_BEEF, 16);

        // Slot 1, one wait state
        rd[1] = 32'hCAFE_F00D;
        ack_delay[1] = 1;
        access("rd_s1", 32'hd000_0008, 1'b0, 32'h0, 4'b0010, 1'b0, 32'hCAFE_F00D, 3);

        // Reset during ACCESS aborts without a ready pulse
        ack_delay[1] = 255;
        addr_bus = 32'hd000_0000;
        mem_w    = 1'b0;
        req      = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_sel_before", 32'(slot_sel), 32'b0010);
        rst = 1'b0;
        #1;
        check("abort_sel_now", 32'(slot_sel), 32'd0);
        check("abort_ready",   32'(ready), 32'd0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_ready_later", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rdata_cleared", cpu_data4bus, 32'h0);
        check_log("abort", 32'h0, 8'h0);

        // Fresh read on slot 1 after the abort
        rd[1] = 32'h0BAD_C0DE;
        ack_delay[1] = 0;
        access("post_rst_s1", 32'hd000_0004, 1'b0, 32'h0, 4'b0010, 1'b0, 32'h0BAD_C0DE, 2);

        // 300 consecutive misses saturate the fault counter
        for (int i = 0; i < 300; i++)
            access("miss_loop", 32'h1000_0000 | (i << 2), 1'b0, 32'h0, 4'b0000,
                   1'b1, 32'h0BAD_C0DE, 1);
        check_log("sat", 32'h1000_0000 | (299 << 2), 8'hff);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mio_bus_ws.md
Name: mio_bus_ws

Overview:
Parametrised memory-mapped I/O bus controller with per-slot address decode, a registered request/acknowledge handshake, per-access timeout and error reporting. Sits between the CPU data port and NSLOT peripheral slots (data RAM, GPIO, counter, PS/2, ...). It replaces the purely combinational decode with a registered one, so slow peripherals can insert wait states.

Parameters:
NSLOT, 4, number of peripheral slots (1..8)
DW, 32, data width
SLOT_TAG, {4'hf,4'he,4'hd,4'h0}, packed NSLOT*4 bits; slot i matches when addr_bus[31:28]==SLOT_TAG[4i+3:4i]
RAM_AW, 11, word-address width driven to slots (slot_addr = addr_bus[RAM_AW+1:2])
TIMEOUT, 15, max wait cycles after slot_sel asserts before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  1  CPU access request; sampled only in IDLE
mem_w  in  1  1=write, 0=read
addr_bus  in  32  byte address
cpu_data2bus  in  DW  write data from CPU
cpu_data4bus  out  DW  registered read data to CPU
ready  out  1  one-cycle completion pulse
err  out  1  valid with ready; 1=decode miss or timeout
slot_sel  out  NSLOT  one-hot slot select, held for the whole access
slot_we  out  1  write strobe, equals latched mem_w while any slot_sel bit is high
slot_addr  out  RAM_AW  latched word address
slot_wdata  out  DW  latched write data
slot_rdata  in  NSLOT*DW  per-slot read data, slot i at [DW*i+DW-1:DW*i]
slot_ack  in  NSLOT  slot completion; only the selected bit is honoured
err_addr  out  32  last faulting address (feature only)
err_cnt  out  8  saturating fault count (feature only)

Behaviour:
- Reset (rst=0, async): state=IDLE; cpu_data4bus=0, ready=0, err=0, slot_sel=0, slot_we=0, slot_addr=0, slot_wdata=0, wait counter=0, err_addr=0, err_cnt=0.
- FSM IDLE -> ACCESS -> RESP -> IDLE; on decode miss IDLE -> RESP directly.
- IDLE: if req, latch addr, data and mem_w, and decode. Lowest-index matching slot wins (duplicate tags are legal; the lower index has priority). On a match go to ACCESS with slot_sel one-hot next cycle. On no match go to RESP with err pending.
- ACCESS: slot_sel and slot_we held stable; wait counter increments each cycle.
  - If slot_ack of the selected slot is 1: on a read, register slot_rdata of that slot into cpu_data4bus; go to RESP, err=0.
  - Else, if the counter reaches TIMEOUT: go to RESP, err=1, cpu_data4bus unchanged.
  - An ack and the timeout in the same cycle count as an ack.
- RESP: ready=1 for exactly one cycle, err valid. slot_sel=0 and counter cleared. Next state IDLE.
- Latency: req at cycle N, combinational ack -> ready at N+2. A k-cycle ack delay adds k cycles. A miss gives ready at N+1.
- Writes never modify cpu_data4bus. Non-selected slot_ack bits are ignored.
- req outside IDLE is ignored; the CPU holds req until ready. req high in RESP does not start an access until the next cycle in IDLE.
- Reset asserted mid-access aborts immediately: slot_sel drops asynchronously and no ready is produced.

Optional Feature:
MIO_BUS_ERRLOG_EN:
- Defined: each err completion loads err_addr with the latched address and increments err_cnt, saturating at 8'hff.
- Undefined: err_addr and err_cnt are tied to 0 and no logging registers are synthesised. The ports exist in both builds.

Decomposition:
- Package mio_bus_pkg holds:
  - state enum (IDLE, ACCESS, RESP)
  - default SLOT_TAG constant
  - slot-index constants (SLOT_RAM=0, SLOT_PS2=1, SLOT_GPIOE=2, SLOT_GPIOF=3)
  - ERR_CNT_W=8
- One sub-module, mio_addr_dec: a combinational priority decoder from addr_bus[31:28] and SLOT_TAG to a one-hot select plus a hit flag.

Test Plan:
- Read slot 0 (addr 32'h0000_0010, ack tied high, rdata0=32'h1234_5678) -> slot_addr=4, ready at N+2, err=0, cpu_data4bus=32'h1234_5678.
- Write slot 2 (addr 32'he000_0000, data 32'hA5A5_0001, ack after 3 cycles) -> slot_sel=4'b0100 and slot_we=1 for 4 cycles, ready at N+5, cpu_data4bus unchanged.
- Unmapped addr 32'h5000_0000 -> no slot_sel, ready at N+1 with err=1; with MIO_BUS_ERRLOG_EN, err_addr=32'h5000_0000 and err_cnt=1.
- Slot 3 read, ack never asserted, TIMEOUT=15 -> err=1 and ready exactly 15 cycles after slot_sel rises; cpu_data4bus retains its old value.
- Ack on the same cycle the counter hits TIMEOUT -> err=0 and data captured. Separately, 300 consecutive misses -> err_cnt saturates at 8'hff.
- rst pulled low during ACCESS -> slot_sel=0 immediately, no ready. After release, a new read on slot 1 completes normally.
